// File: rtl/barret_3623_pkg.sv
// Shared constants for the Barrett mod-3623 reducer and its round-robin front end.
package barret_3623_pkg;

   localparam int N_REQ = 4;
   localparam int Q     = 3623;
   localparam int MU    = 4630;   // floor(2^24 / Q)
   localparam int K     = 12;
   localparam int OP_W  = 23;
   localparam int RES_W = 12;
   localparam int R2_W  = 14;
   localparam int Q1_W  = 24;
   localparam int ID_W  = $clog2(N_REQ);

endpackage

// File: rtl/barret_arbiter_3623_if.sv
// Request/response bundle between the requesters and the shared reducer.
interface barret_arbiter_3623_if #(
   parameter int N_REQ = barret_3623_pkg::N_REQ
);

   localparam int ID_W = $clog2(N_REQ);

   logic                                   en;
   logic [N_REQ-1:0]                       req_valid;
   logic [N_REQ*barret_3623_pkg::OP_W-1:0] req_data;
   logic [N_REQ-1:0]                       req_ready;
   logic                                   rsp_valid;
   logic [ID_W-1:0]                        rsp_id;
   logic [barret_3623_pkg::RES_W-1:0]      rsp_data;
   logic                                   busy;

   modport master (
      output en, req_valid, req_data,
      input  req_ready, rsp_valid, rsp_id, rsp_data, busy
   );

   modport slave (
      input  en, req_valid, req_data,
      output req_ready, rsp_valid, rsp_id, rsp_data, busy
   );

endinterface

// File: rtl/barret_pipe_3623.sv
// Three-stage Barrett reduction: estimate quotient, subtract, then two corrections.
module barret_pipe_3623
   import barret_3623_pkg::*;
#(
   parameter int Q    = barret_3623_pkg::Q,
   parameter int MU   = barret_3623_pkg::MU,
   parameter int K    = barret_3623_pkg::K,
   parameter int ID_W = barret_3623_pkg::ID_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [OP_W-1:0]  in_data,
   input  logic [ID_W-1:0]  in_id,
   output logic             out_valid,
   output logic [RES_W-1:0] out_data,
   output logic [ID_W-1:0]  out_id,
   output logic             busy
);

   logic             s1_valid, s2_valid;
   logic [OP_W-1:0]  s1_din;
   logic [Q1_W-1:0]  s1_q1;
   logic [ID_W-1:0]  s1_id, s2_id;
   logic [R2_W-1:0]  s2_r2;
   logic [Q1_W-1:0]  q1_next, q_times_mod;
   logic [R2_W-1:0]  r2_next, r3_once;
   logic [RES_W-1:0] r3_twice;

   assign q1_next     = Q1_W'(in_data >> K) * Q1_W'(MU);
   assign q_times_mod = (s1_q1 >> K) * Q1_W'(Q);
   // Quotient estimate undershoots by at most 2, so the remainder fits in 14 bits.
   assign r2_next     = R2_W'(Q1_W'(s1_din) - q_times_mod);

   // NOTE: defaulting every output at the top of always_comb prevents latch inference.
   always_comb begin
      r3_once = s2_r2;
      if (s2_r2 >= R2_W'(Q)) r3_once = s2_r2 - R2_W'(Q);
      r3_twice = RES_W'(r3_once);
      if (r3_once >= R2_W'(Q)) r3_twice = RES_W'(r3_once - R2_W'(Q));
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
      end else begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_data <= r3_twice;
            out_id   <= s2_id;
         end
      end
   end

   // NOTE: interior datapath registers need no reset; the valid bits already qualify them.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         s1_din <= in_data;
         s1_q1  <= q1_next;
         s1_id  <= in_id;
      end
      if (s1_valid) begin
         s2_r2 <= r2_next;
         s2_id <= s1_id;
      end
   end

   assign busy = s1_valid | s2_valid | out_valid;

endmodule

// File: rtl/barret_arbiter_3623.sv
// Round-robin front end sharing one Barrett mod-Q reducer among N_REQ requesters.
module barret_arbiter_3623
   import barret_3623_pkg::*;
#(
   parameter int N_REQ = barret_3623_pkg::N_REQ,
   parameter int Q     = barret_3623_pkg::Q,
   parameter int MU    = barret_3623_pkg::MU,
   parameter int K     = barret_3623_pkg::K
) (
   input logic                  clk,
   input logic                  rst,
   barret_arbiter_3623_if.slave bus
);

   localparam int PTR_W = $clog2(N_REQ);

   logic [N_REQ-1:0] grant;
   logic [PTR_W-1:0] grant_id, ptr, idx;
   logic [OP_W-1:0]  grant_data;
   logic             acc_valid;
   logic [OP_W-1:0]  acc_data;
   logic [PTR_W-1:0] acc_id;
   logic             pipe_busy;

   // Scan from the pointer upward, wrapping; the first valid requester wins.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      idx      = '0;
      for (int off = 0; off < N_REQ; off++) begin
         idx = PTR_W'((int'(ptr) + off) % N_REQ);
         if (bus.en && bus.req_valid[idx] && grant == '0) begin
            grant[idx] = 1'b1;
            grant_id   = idx;
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant[i]) grant_data = bus.req_data[i*OP_W +: OP_W];
   end

   assign bus.req_ready = grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         acc_valid <= 1'b0;
      end else begin
         acc_valid <= |grant;
         if (|grant) ptr <= (grant_id == PTR_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (|grant) begin
         acc_data <= grant_data;
         acc_id   <= grant_id;
      end
   end

   barret_pipe_3623 #(
      .Q    (Q),
      .MU   (MU),
      .K    (K),
      .ID_W (PTR_W)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (acc_valid),
      .in_data   (acc_data),
      .in_id     (acc_id),
      .out_valid (bus.rsp_valid),
      .out_data  (bus.rsp_data),
      .out_id    (bus.rsp_id),
      .busy      (pipe_busy)
   );

   // The capture register holds an operation in flight too, so it counts towards busy.
   assign bus.busy = acc_valid | pipe_busy;

endmodule
